// File: rtl/uno_hand_store_if.sv
// Hand-store bus: insert/play handshakes from the game controller plus hand status back to controller and display.
interface uno_hand_store_if #(
  parameter int MAX_CARDS = 20
);
  localparam int IDX_W = $clog2(MAX_CARDS);
  localparam int CNT_W = $clog2(MAX_CARDS + 1);

  logic                         i_clear;
  logic                         i_ins_valid;
  logic [5:0]                   i_ins_card;
  logic                         o_ins_ready;
  logic                         i_play_valid;
  logic [IDX_W-1:0]             i_play_idx;
  logic [5:0]                   i_top_card;
  logic [1:0]                   i_cur_color;
  logic                         i_pending_draw;
  logic                         o_play_ok;
  logic                         o_play_reject;
  logic [5:0]                   o_play_card;
  logic                         o_ins_done;
  logic                         o_ins_drop;
  logic [MAX_CARDS-1:0][5:0]    o_hands;
  logic [CNT_W-1:0]             o_count;
  logic                         o_full;
  logic                         o_empty;
  logic                         o_playable;

  modport master (
    output i_clear, i_ins_valid, i_ins_card, i_play_valid, i_play_idx,
           i_top_card, i_cur_color, i_pending_draw,
    input  o_ins_ready, o_play_ok, o_play_reject, o_play_card, o_ins_done,
           o_ins_drop, o_hands, o_count, o_full, o_empty, o_playable
  );

  modport slave (
    input  i_clear, i_ins_valid, i_ins_card, i_play_valid, i_play_idx,
           i_top_card, i_cur_color, i_pending_draw,
    output o_ins_ready, o_play_ok, o_play_reject, o_play_card, o_ins_done,
           o_ins_drop, o_hands, o_count, o_full, o_empty, o_playable
  );
endinterface

// File: rtl/uno_hand_store.sv
// Sorted single-player hand; insert done 2 cycles after accept, play verdict 2 (reject) / 3 (ok) cycles after request.
// o_ins_ready drops outside idle or while a play/clear is requested; UNO_STACK_RULE_EN enables penalty-stacking legality.
module uno_hand_store #(
  parameter int         MAX_CARDS  = 20,
  parameter logic [5:0] EMPTY_CODE = 6'h3F
) (
  input logic             i_clk,
  input logic             i_rst_n,
  uno_hand_store_if.slave bus
);

  localparam int IDX_W = $clog2(MAX_CARDS);
  localparam int CNT_W = $clog2(MAX_CARDS + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_CARDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INSERT,
    S_CHECK,
    S_REMOVE
  } state_t;

  typedef logic [MAX_CARDS-1:0][5:0] hand_t;

  // Wild cards collapse their colour so all wilds sort after every coloured card.
  function automatic logic [6:0] sort_key(input logic [5:0] card);
    logic wild;
    wild = (card[3:0] >= 4'd13);
    return {wild, (wild ? 2'b00 : card[5:4]), card[3:0]};
  endfunction

  function automatic logic is_legal(input logic [5:0] card, input logic [5:0] top,
                                    input logic [1:0] color, input logic pend);
    logic ok;
    if (card[3:0] >= 4'd13) begin
      ok = 1'b1;
    end else if (top[3:0] >= 4'd13) begin
      ok = (card[5:4] == color);
    end else begin
      ok = (card[5:4] == top[5:4]) || (card[3:0] == top[3:0]);
    end
    if (pend) begin
      ok = (card[3:0] == 4'd12) || (card[3:0] == 4'd14);
    end
    return ok;
  endfunction

  state_t           state_q, state_d;
  hand_t            hands_q, hands_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [5:0]       ins_card_q, ins_card_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [5:0]       play_card_q, play_card_d;
  logic             ins_done_q, ins_done_d;
  logic             ins_drop_q, ins_drop_d;
  logic             play_ok_q, play_ok_d;
  logic             play_rej_q, play_rej_d;

  logic             pend_eff;
  logic             full;
  logic [CNT_W-1:0] ins_pos;
  hand_t            ins_hand;
  hand_t            rem_hand;
  logic [5:0]       sel_card;
  logic             idx_valid;
  logic             sel_legal;
  logic             playable;

`ifdef UNO_STACK_RULE_EN
  assign pend_eff = bus.i_pending_draw;
`else
  logic unused_pending_draw;
  assign unused_pending_draw = bus.i_pending_draw;
  assign pend_eff = 1'b0;
`endif

  assign full = (count_q == FULL_CNT);

  // Equal keys count as "before", so a new card lands after its duplicates.
  always_comb begin
    ins_pos = '0;
    for (int j = 0; j < MAX_CARDS; j++) begin
      if ((CNT_W'(j) < count_q) && (sort_key(hands_q[j]) <= sort_key(ins_card_q))) begin
        ins_pos = ins_pos + CNT_W'(1);
      end
    end
  end

  always_comb begin
    ins_hand    = hands_q;
    ins_hand[0] = (ins_pos == '0) ? ins_card_q : hands_q[0];
    for (int j = 1; j < MAX_CARDS; j++) begin
      if (CNT_W'(j) < ins_pos) begin
        ins_hand[j] = hands_q[j];
      end else if (CNT_W'(j) == ins_pos) begin
        ins_hand[j] = ins_card_q;
      end else begin
        ins_hand[j] = hands_q[j-1];
      end
    end
  end

  always_comb begin
    rem_hand = hands_q;
    for (int j = 0; j < MAX_CARDS - 1; j++) begin
      if (IDX_W'(j) >= idx_q) begin
        rem_hand[j] = hands_q[j+1];
      end
    end
    rem_hand[MAX_CARDS-1] = EMPTY_CODE;
  end

  // Loop select keeps out-of-range indices (idx >= MAX_CARDS) well defined.
  always_comb begin
    sel_card = EMPTY_CODE;
    for (int j = 0; j < MAX_CARDS; j++) begin
      if (IDX_W'(j) == idx_q) begin
        sel_card = hands_q[j];
      end
    end
  end

  assign idx_valid = (CNT_W'(idx_q) < count_q);
  assign sel_legal = is_legal(sel_card, bus.i_top_card, bus.i_cur_color, pend_eff);

  always_comb begin
    playable = 1'b0;
    for (int j = 0; j < MAX_CARDS; j++) begin
      if ((CNT_W'(j) < count_q) &&
          is_legal(hands_q[j], bus.i_top_card, bus.i_cur_color, pend_eff)) begin
        playable = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    hands_d     = hands_q;
    count_d     = count_q;
    ins_card_d  = ins_card_q;
    idx_d       = idx_q;
    play_card_d = play_card_q;
    ins_done_d  = 1'b0;
    ins_drop_d  = 1'b0;
    play_ok_d   = 1'b0;
    play_rej_d  = 1'b0;

    if (bus.i_clear) begin
      hands_d = {MAX_CARDS{EMPTY_CODE}};
      count_d = '0;
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_play_valid) begin
            idx_d   = bus.i_play_idx;
            state_d = S_CHECK;
          end else if (bus.i_ins_valid) begin
            if (full) begin
              ins_drop_d = 1'b1;
            end else begin
              ins_card_d = bus.i_ins_card;
              state_d    = S_INSERT;
            end
          end
        end
        S_INSERT: begin
          if (!full) begin
            hands_d    = ins_hand;
            count_d    = count_q + CNT_W'(1);
            ins_done_d = 1'b1;
          end
          state_d = S_IDLE;
        end
        S_CHECK: begin
          if (!idx_valid || !sel_legal) begin
            play_rej_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            play_card_d = sel_card;
            state_d     = S_REMOVE;
          end
        end
        S_REMOVE: begin
          hands_d   = rem_hand;
          count_d   = count_q - CNT_W'(1);
          play_ok_d = 1'b1;
          state_d   = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      hands_q     <= {MAX_CARDS{EMPTY_CODE}};
      count_q     <= '0;
      ins_card_q  <= '0;
      idx_q       <= '0;
      play_card_q <= '0;
      ins_done_q  <= 1'b0;
      ins_drop_q  <= 1'b0;
      play_ok_q   <= 1'b0;
      play_rej_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hands_q     <= hands_d;
      count_q     <= count_d;
      ins_card_q  <= ins_card_d;
      idx_q       <= idx_d;
      play_card_q <= play_card_d;
      ins_done_q  <= ins_done_d;
      ins_drop_q  <= ins_drop_d;
      play_ok_q   <= play_ok_d;
      play_rej_q  <= play_rej_d;
    end
  end

  assign bus.o_ins_ready   = (state_q == S_IDLE) && !bus.i_play_valid && !bus.i_clear;
  assign bus.o_play_ok     = play_ok_q;
  assign bus.o_play_reject = play_rej_q;
  assign bus.o_play_card   = play_card_q;
  assign bus.o_ins_done    = ins_done_q;
  assign bus.o_ins_drop    = ins_drop_q;
  assign bus.o_hands       = hands_q;
  assign bus.o_count       = count_q;
  assign bus.o_full        = full;
  assign bus.o_empty       = (count_q == '0);
  assign bus.o_playable    = playable;

endmodule

// File: tb/tb_uno_hand_store.sv
// Bench for uno_hand_store: queue-based hand model, per-cycle status compare, directed and random insert/play traffic.
module tb_uno_hand_store;
  localparam int MAX   = 20;
  localparam int IDX_W = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uno_hand_store_if #(.MAX_CARDS(MAX)) bus ();

  uno_hand_store #(.MAX_CARDS(MAX), .EMPTY_CODE(6'h3F)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  logic [5:0] mdl[$];
  int  n_checks;
  int  n_errors;
  bit  cmp_en;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] key(input logic [5:0] c);
    if (c[3:0] >= 4'd13) return {1'b1, 2'b00, c[3:0]};
    return {1'b0, c[5:4], c[3:0]};
  endfunction

  function automatic bit legal(input logic [5:0] c, input logic [5:0] t,
                               input logic [1:0] col, input logic pend);
`ifdef UNO_STACK_RULE_EN
    if (pend) return (c[3:0] == 4'd12) || (c[3:0] == 4'd14);
`endif
    if (c[3:0] >= 4'd13) return 1'b1;
    if (t[3:0] >= 4'd13) return c[5:4] == col;
    return (c[5:4] == t[5:4]) || (c[3:0] == t[3:0]);
  endfunction

  function automatic bit mdl_playable();
    foreach (mdl[i])
      if (legal(mdl[i], bus.i_top_card, bus.i_cur_color, bus.i_pending_draw)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [MAX*6-1:0] exp_hands();
    logic [MAX*6-1:0] e;
    for (int j = 0; j < MAX; j++) e[j*6 +: 6] = (j < mdl.size()) ? mdl[j] : 6'h3F;
    return e;
  endfunction

  function automatic void mdl_insert(input logic [5:0] c);
    int p = 0;
    foreach (mdl[i]) if (key(mdl[i]) <= key(c)) p++;
    mdl.insert(p, c);
  endfunction

  function automatic logic [5:0] rand_card();
    logic [1:0] col = 2'($urandom_range(0, 3));
    logic [3:0] val = 4'($urandom_range(0, 14));
    return {col, val};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", bus.o_count, mdl.size());
      chk("hands", bus.o_hands, exp_hands());
      chk("full", bus.o_full, mdl.size() == MAX);
      chk("empty", bus.o_empty, mdl.size() == 0);
      chk("playable", bus.o_playable, mdl_playable());
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called right after the edge that accepted an insert of c.
  task automatic ins_tail(input logic [5:0] c, input bit full_exp);
    bus.i_ins_valid = 1'b0;
    bus.i_ins_card  = 6'($urandom);
    @(negedge clk);
    chk("ins_drop", bus.o_ins_drop, full_exp);
    chk("ins_done_early", bus.o_ins_done, 0);
    chk("ins_ready_busy", bus.o_ins_ready, full_exp);
    if (!full_exp) begin
      step();
      mdl_insert(c);
      @(negedge clk);
      chk("ins_done", bus.o_ins_done, 1);
      chk("ins_drop_spurious", bus.o_ins_drop, 0);
    end
    step();
  endtask

  task automatic do_insert(input logic [5:0] c);
    bit full_exp = (mdl.size() == MAX);
    bus.i_ins_valid = 1'b1;
    bus.i_ins_card  = c;
    @(negedge clk);
    chk("ins_ready", bus.o_ins_ready, 1);
    step();
    ins_tail(c, full_exp);
  endtask

  task automatic do_play(input int idx, input bit hold_ins, input logic [5:0] hold_card,
                         output bit model_ok);
    logic [5:0] exp_card = 6'h00;
    model_ok = 1'b0;
    if (idx < mdl.size()) begin
      exp_card = mdl[idx];
      model_ok = legal(mdl[idx], bus.i_top_card, bus.i_cur_color, bus.i_pending_draw);
    end
    if (hold_ins) begin
      bus.i_ins_valid = 1'b1;
      bus.i_ins_card  = hold_card;
    end
    bus.i_play_valid = 1'b1;
    bus.i_play_idx   = IDX_W'(idx);
    @(negedge clk);
    chk("ready_low_on_play", bus.o_ins_ready, 0);
    step();
    bus.i_play_valid = 1'b0;
    bus.i_play_idx   = IDX_W'($urandom);
    @(negedge clk);
    chk("play_early", {bus.o_play_ok, bus.o_play_reject}, 2'b00);
    chk("ready_check", bus.o_ins_ready, 0);
    chk("no_ins_done_check", bus.o_ins_done, 0);
    step();
    @(negedge clk);
    chk("play_reject", bus.o_play_reject, !model_ok);
    chk("play_ok_early", bus.o_play_ok, 0);
    chk("no_ins_done_verdict", bus.o_ins_done, 0);
    if (model_ok) begin
      chk("play_card_load", bus.o_play_card, exp_card);
      chk("ready_remove", bus.o_ins_ready, 0);
      step();
      mdl.delete(idx);
      @(negedge clk);
      chk("play_ok", bus.o_play_ok, 1);
      chk("play_reject_spurious", bus.o_play_reject, 0);
      chk("play_card", bus.o_play_card, exp_card);
      chk("no_ins_done_ok", bus.o_ins_done, 0);
    end
    if (hold_ins) begin
      bit full_exp;
      chk("ready_after_play", bus.o_ins_ready, 1);
      full_exp = (mdl.size() == MAX);
      step();
      ins_tail(hold_card, full_exp);
    end else begin
      step();
    end
  endtask

  task automatic do_clear();
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    mdl.delete();
    @(negedge clk);
    chk("clear_no_pulse", {bus.o_ins_done, bus.o_play_ok, bus.o_play_reject}, 3'b000);
    step();
  endtask

  initial begin
    bit mok;
    logic [MAX*6-1:0] all_empty;
    n_checks = 0;
    n_errors = 0;
    cmp_en   = 1'b0;
    bus.i_clear = 1'b0;        bus.i_ins_valid = 1'b0;  bus.i_ins_card = 6'h00;
    bus.i_play_valid = 1'b0;   bus.i_play_idx = '0;     bus.i_top_card = 6'h00;
    bus.i_cur_color = 2'b00;   bus.i_pending_draw = 1'b0;
    for (int j = 0; j < MAX; j++) all_empty[j*6 +: 6] = 6'h3F;

    repeat (2) @(negedge clk);
    chk("rst_count", bus.o_count, 0);
    chk("rst_empty", bus.o_empty, 1);
    chk("rst_full", bus.o_full, 0);
    chk("rst_ready", bus.o_ins_ready, 1);
    chk("rst_pulses", {bus.o_play_ok, bus.o_play_reject, bus.o_ins_done, bus.o_ins_drop}, 4'b0000);
    chk("rst_play_card", bus.o_play_card, 0);
    chk("rst_hands", bus.o_hands, all_empty);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Sorted insertion
    do_insert(6'h0C); do_insert(6'h05); do_insert(6'h1D); do_insert(6'h03);
    chk("pin_slot0", bus.o_hands[0], 6'h03);
    chk("pin_slot1", bus.o_hands[1], 6'h05);
    chk("pin_slot2", bus.o_hands[2], 6'h0C);
    chk("pin_slot3", bus.o_hands[3], 6'h1D);
    chk("pin_count4", bus.o_count, 4);

    // Colour/value matching on green 3
    do_clear();
    do_insert(6'h15); do_insert(6'h03);
    bus.i_top_card = 6'h23;
    do_play(1, 1'b0, 6'h00, mok);
    chk("pin_reject_y5", mok, 0);
    do_play(0, 1'b0, 6'h00, mok);
    chk("pin_ok_r3", mok, 1);
    chk("pin_play_card", bus.o_play_card, 6'h03);
    chk("pin_slot0_15", bus.o_hands[0], 6'h15);

    // Wild top uses declared colour
    bus.i_top_card = 6'h0D; bus.i_cur_color = 2'b01;
    @(negedge clk);
    chk("pin_playable_yel", bus.o_playable, 1);
    step();
    bus.i_cur_color = 2'b00;
    @(negedge clk);
    chk("pin_playable_red", bus.o_playable, 0);
    step();
    do_play(0, 1'b0, 6'h00, mok);
    chk("pin_wild_reject", mok, 0);
    bus.i_cur_color = 2'b01;
    step();
    do_play(0, 1'b0, 6'h00, mok);
    chk("pin_wild_ok", mok, 1);

    // Full hand
    do_clear();
    for (int i = 0; i < MAX; i++) do_insert(rand_card());
    do_insert(6'h01);
    chk("pin_full", bus.o_full, 1);
    chk("pin_count20", bus.o_count, 20);
    do_play(25, 1'b0, 6'h00, mok);
    chk("pin_idx25_reject", mok, 0);

    // Play beats a simultaneous insert, which then completes
    do_clear();
    do_insert(6'h12); do_insert(6'h07);
    bus.i_top_card = 6'h17; bus.i_cur_color = 2'b00;
    do_play(0, 1'b1, 6'h2A, mok);
    chk("pin_both_ok", mok, 1);
    chk("pin_both_s0", bus.o_hands[0], 6'h12);
    chk("pin_both_s1", bus.o_hands[1], 6'h2A);

    // Clear aborts an insert in flight
    bus.i_ins_valid = 1'b1; bus.i_ins_card = 6'h33;
    @(negedge clk);
    chk("ready_before_abort", bus.o_ins_ready, 1);
    step();
    bus.i_ins_valid = 1'b0;
    bus.i_clear = 1'b1;
    step();
    bus.i_clear = 1'b0;
    mdl.delete();
    @(negedge clk);
    chk("abort_no_done", bus.o_ins_done, 0);
    chk("pin_abort_empty", bus.o_empty, 1);
    step();
    @(negedge clk);
    chk("abort_no_late_done", bus.o_ins_done, 0);
    step();

`ifdef UNO_STACK_RULE_EN
    bus.i_top_card = 6'h0C; bus.i_cur_color = 2'b00; bus.i_pending_draw = 1'b1;
    do_insert(6'h05); do_insert(6'h1C); do_insert(6'h0D);
    @(negedge clk);
    chk("pin_stack_playable", bus.o_playable, 1);
    step();
    do_play(0, 1'b0, 6'h00, mok);
    chk("pin_stack_05", mok, 0);
    do_play(1, 1'b0, 6'h00, mok);
    chk("pin_stack_1C", mok, 1);
    do_play(1, 1'b0, 6'h00, mok);
    chk("pin_stack_0D", mok, 0);
    bus.i_pending_draw = 1'b0;
    do_clear();
`endif

    // Random traffic
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 99);
      bus.i_top_card     = rand_card();
      bus.i_cur_color    = 2'($urandom_range(0, 3));
      bus.i_pending_draw = ($urandom_range(0, 3) == 0);
      if (r < 48) begin
        do_insert(rand_card());
      end else if (r < 97) begin
        int idx;
        if (mdl.size() > 0 && $urandom_range(0, 9) < 8) idx = $urandom_range(0, mdl.size() - 1);
        else idx = $urandom_range(0, 31);
        do_play(idx, ($urandom_range(0, 4) == 0), rand_card(), mok);
      end else begin
        do_clear();
      end
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
